vga_sync_to_count_lock: RTL and testbench
=========================================

# vga_sync_to_count_lock

Receive-side VGA timing decoder. It takes a raw HSync/VSync pair in the active-video-high sync convention used by our sync pulse generator, where sync is high while the counter is in the active region. From that pair it recovers column and row counts aligned to a one-cycle-delayed copy of the syncs. It also checks that the incoming frame geometry matches the parameters and reports lock. It sits between a sync source (a local generator or an external timing input) and pixel-rendering logic that needs coordinates.

## Interface
- TOTAL_COLS, 800, clocks per line; must be ≤ 1024.
- TOTAL_ROWS, 525, lines per frame; must be ≤ 1024.
- LOCK_FRAMES, 2, consecutive good frames required before o_Locked asserts; range 1..15.

Ports:
- i_Clk  in  1  pixel clock; the block uses only this clock.
- Reset  in  1  asynchronous, active-high reset.
- i_HSync  in  1  raw line sync, high during active columns.
- i_VSync  in  1  raw frame sync, high during active rows.
- o_HSync  out  1  i_HSync delayed 1 cycle.
- o_VSync  out  1  i_VSync delayed 1 cycle.
- o_Col_Count  out  10  column of the current o_HSync/o_VSync sample.
- o_Row_Count  out  10  row of the current sample.
- o_Frame_Start  out  1  one-cycle pulse on the cycle where o_VSync first goes high.
- o_Locked  out  1  geometry verified for LOCK_FRAMES consecutive frames.
- o_Err  out  1  one-cycle pulse on any detected geometry violation.

## Operation
- **Input stage.** i_HSync and i_VSync are registered into o_HSync and o_VSync.
- **Edge detection.** Rising edges are decoded combinationally:
  - v_rise = i_VSync & ~o_VSync
  - h_rise = i_HSync & ~o_HSync
- **State.** r_Seen (a first frame start has occurred) and a 4-bit good-frame counter r_Good.
- **Count update on each clock, by priority:**
  1. **v_rise.** Counts load 0,0 and r_Seen is set.
     - If r_Seen was already 1, the pre-load counts are compared with (TOTAL_COLS-1, TOTAL_ROWS-1).
     - On a match, r_Good increments, saturating at LOCK_FRAMES.
     - On a mismatch, an error is raised.
  2. **h_rise with r_Seen=1.** Col loads 0 and row increments, wrapping at TOTAL_ROWS-1 to 0.
     - If the pre-load col is not TOTAL_COLS-1, an error is raised.
  3. **Otherwise, with r_Seen=1.** Col increments.
     - At TOTAL_COLS-1, col wraps to 0 and row increments.
     - If row is TOTAL_ROWS-1 at that point, row wraps to 0 and an error is raised (missing VSync).
  4. **r_Seen=0.** Counts hold at 0.
- **Error handling.** Any error pulses o_Err for one cycle, clears r_Good to 0 and deasserts o_Locked. The count update for that cycle still completes, so the block re-aligns to the incoming syncs.
- **Lock output.** o_Locked = (r_Good == LOCK_FRAMES), registered.
- **Frame-start pulse.** o_Frame_Start is the registered v_rise.
- **First frame.** The first v_rise after reset is neither good nor an error.
- **Simultaneous HSync and VSync rise.** v_rise has priority and no HSync check is made on that cycle.

## Timing
- **Reset values.** All outputs are 0: o_HSync, o_VSync, both counts, o_Frame_Start, o_Locked, o_Err. r_Seen and r_Good also reset to 0.
- **Latency.** 1 cycle from an input sync change to o_HSync/o_VSync. The counts are exactly aligned with those outputs: the first cycle with o_VSync=1 after a rise shows col=0, row=0 and o_Frame_Start=1.
- **Lock time.** o_Locked rises 1 cycle after the v_rise that completes the LOCK_FRAMES-th good frame. With nominal input and LOCK_FRAMES=2, that is the 3rd frame start after reset.
- **o_Err timing.** o_Err is asserted in the same output cycle as the counts that were re-aligned.
- **Reset mid-operation.** Reset immediately clears lock and counts. Decoding restarts as if from power-up, so the next v_rise is treated as the first frame.
- **Throughput.** One sample per clock, with no stalls or back-pressure.

## Test plan
- **Reset and first frame.** Assert Reset, then drive a nominal 800×525 stream from our sync generator.
  - Before the first VSync rise, outputs stay 0.
  - One cycle after the first VSync rise: o_Frame_Start=1, col=0, row=0, o_Err never pulses.
  - o_Locked=1 one cycle after the 3rd frame start.
- **Counting and wrap** (TOTAL_COLS=10, TOTAL_ROWS=6).
  - Col runs 0..9 then returns to 0 while row steps.
  - At frame end, o_Row_Count=5 and o_Col_Count=9 immediately before the next o_Frame_Start.
- **Short line** (locked).
  - Stimulus: one HSync rise arrives when col=7 of 10.
  - Required: o_Err pulses for exactly 1 cycle, o_Locked drops, the next col is 0 and row increments.
  - Re-lock then follows after LOCK_FRAMES further good frames.
- **Missing VSync.** Suppress one VSync rise.
  - At col=9, row=5 the counts wrap to 0,0 with o_Err=1.
  - The following genuine VSync rise, with mismatched pre-load counts, pulses o_Err again.
- **Simultaneous edges.** HSync and VSync rise on the same cycle.
  - Exactly one o_Frame_Start, counts 0,0, no o_Err.
- **Reset while locked.** Assert Reset mid-line with o_Locked=1.
  - o_Locked=0 and counts are 0 immediately.
  - After release, the first frame start does not count toward lock, so lock returns at the 3rd frame start.

Source files
------------

// File: rtl/vga_sync_to_count_lock_if.sv
// Sync-in / timing-out bundle for vga_sync_to_count_lock.
// The master side is the sync source and pixel consumer; the slave side is the decoder.
interface vga_sync_to_count_lock_if;
  logic       i_HSync;
  logic       i_VSync;
  logic       o_HSync;
  logic       o_VSync;
  logic [9:0] o_Col_Count;
  logic [9:0] o_Row_Count;
  logic       o_Frame_Start;
  logic       o_Locked;
  logic       o_Err;

  modport master (
    output i_HSync, i_VSync,
    input  o_HSync, o_VSync, o_Col_Count, o_Row_Count,
    input  o_Frame_Start, o_Locked, o_Err
  );

  modport slave (
    input  i_HSync, i_VSync,
    output o_HSync, o_VSync, o_Col_Count, o_Row_Count,
    output o_Frame_Start, o_Locked, o_Err
  );
endinterface

// File: rtl/vga_sync_to_count_lock.sv
// Recovers column/row counts from an active-high HSync/VSync pair, aligned to the
// one-cycle-delayed syncs, and reports lock once frame geometry repeats correctly.
module vga_sync_to_count_lock #(
  parameter int TOTAL_COLS  = 800,
  parameter int TOTAL_ROWS  = 525,
  parameter int LOCK_FRAMES = 2
) (
  input logic                     i_Clk,
  input logic                     Reset,
  vga_sync_to_count_lock_if.slave bus
);

  localparam logic [9:0] LAST_COL = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] LAST_ROW = 10'(TOTAL_ROWS - 1);
  localparam logic [3:0] GOOD_MAX = 4'(LOCK_FRAMES);

  logic       hsync_q, vsync_q;
  logic [9:0] col_q, col_d;
  logic [9:0] row_q, row_d;
  logic       seen_q, seen_d;
  logic [3:0] good_q, good_d;
  logic       fs_q;
  logic       locked_q, locked_d;
  logic       err_q, err_d;
  logic       v_rise, h_rise;

  assign v_rise = bus.i_VSync & ~vsync_q;
  assign h_rise = bus.i_HSync & ~hsync_q;

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    seen_d = seen_q;
    good_d = good_q;
    err_d  = 1'b0;

    if (v_rise) begin
      col_d  = '0;
      row_d  = '0;
      seen_d = 1'b1;
      if (seen_q) begin
        if (col_q == LAST_COL && row_q == LAST_ROW) begin
          if (good_q < GOOD_MAX) good_d = good_q + 4'd1;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (seen_q) begin
      if (h_rise || col_q == LAST_COL) begin
        col_d = '0;
        if (h_rise && col_q != LAST_COL) err_d = 1'b1;
        // Running off the last row without a VSync rise means a frame start was missed,
        // whether the line ended by HSync or by the column count.
        if (row_q == LAST_ROW) begin
          row_d = '0;
          err_d = 1'b1;
        end else begin
          row_d = row_q + 10'd1;
        end
      end else begin
        col_d = col_q + 10'd1;
      end
    end

    if (err_d) good_d = '0;
    locked_d = (good_d == GOOD_MAX);
  end

  // Single stage: delayed syncs and the counts that describe them update together.
  always_ff @(posedge i_Clk or posedge Reset) begin
    if (Reset) begin
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      seen_q   <= 1'b0;
      good_q   <= '0;
      fs_q     <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      hsync_q  <= bus.i_HSync;
      vsync_q  <= bus.i_VSync;
      col_q    <= col_d;
      row_q    <= row_d;
      seen_q   <= seen_d;
      good_q   <= good_d;
      fs_q     <= v_rise;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign bus.o_HSync       = hsync_q;
  assign bus.o_VSync       = vsync_q;
  assign bus.o_Col_Count   = col_q;
  assign bus.o_Row_Count   = row_q;
  assign bus.o_Frame_Start = fs_q;
  assign bus.o_Locked      = locked_q;
  assign bus.o_Err         = err_q;

endmodule

// File: tb/tb_vga_sync_to_count_lock.sv
// Bench for vga_sync_to_count_lock on a 10x6 raster (4 active cols, 4 active rows).
module tb_vga_sync_to_count_lock;

  localparam int COLS = 10;
  localparam int ROWS = 6;
  localparam int HACT = 4;
  localparam int VACT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vga_sync_to_count_lock_if ifc ();

  vga_sync_to_count_lock #(
    .TOTAL_COLS(COLS), .TOTAL_ROWS(ROWS), .LOCK_FRAMES(2)
  ) dut (
    .i_Clk(clk),
    .Reset(rst),
    .bus  (ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int hs, vs, col, row, fs, lk, er;
  } vec_t;

  vec_t vecs[12];

  int pass_cnt = 0;
  int total_cnt = 0;
  int errcnt = 0;
  int gc = 0, gr = 0, kk = 0;
  logic vmask = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act != exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic chk_all(input string tag, input int hs, input int vs, input int col,
                         input int row, input int fs, input int lk, input int er);
    chk({tag, ".hsync"}, int'(ifc.o_HSync), hs);
    chk({tag, ".vsync"}, int'(ifc.o_VSync), vs);
    chk({tag, ".col"},   int'(ifc.o_Col_Count), col);
    chk({tag, ".row"},   int'(ifc.o_Row_Count), row);
    chk({tag, ".fs"},    int'(ifc.o_Frame_Start), fs);
    chk({tag, ".lock"},  int'(ifc.o_Locked), lk);
    chk({tag, ".err"},   int'(ifc.o_Err), er);
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
    if (ifc.o_Err) errcnt++;
  endtask

  // Drive the source's current raster position, clock it, then advance the source.
  task automatic gen_step();
    ifc.i_HSync = (gc < HACT);
    ifc.i_VSync = (gr < VACT) && !vmask;
    clk1();
    kk++;
    if (gc == COLS - 1) begin
      gc = 0;
      gr = (gr == ROWS - 1) ? 0 : gr + 1;
    end else begin
      gc++;
    end
  endtask

  task automatic wait_fs(input string name);
    int n;
    n = 0;
    do begin
      gen_step();
      n++;
    end while (!ifc.o_Frame_Start && n < 200);
    chk({name, ".found"}, int'(ifc.o_Frame_Start), 1);
  endtask

  initial begin
    vecs[0]  = '{0,   1, 1, 0, 0, 1, 0, 0};
    vecs[1]  = '{1,   1, 1, 1, 0, 0, 0, 0};
    vecs[2]  = '{3,   1, 1, 3, 0, 0, 0, 0};
    vecs[3]  = '{4,   0, 1, 4, 0, 0, 0, 0};
    vecs[4]  = '{9,   0, 1, 9, 0, 0, 0, 0};
    vecs[5]  = '{10,  1, 1, 0, 1, 0, 0, 0};
    vecs[6]  = '{44,  0, 0, 4, 4, 0, 0, 0};
    vecs[7]  = '{59,  0, 0, 9, 5, 0, 0, 0};
    vecs[8]  = '{60,  1, 1, 0, 0, 1, 0, 0};
    vecs[9]  = '{119, 0, 0, 9, 5, 0, 0, 0};
    vecs[10] = '{120, 1, 1, 0, 0, 1, 1, 0};
    vecs[11] = '{121, 1, 1, 1, 0, 0, 1, 0};

    // Reset holds everything at zero even with active syncs applied.
    ifc.i_HSync = 1'b1;
    ifc.i_VSync = 1'b1;
    repeat (3) clk1();
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);

    rst = 1'b0;
    ifc.i_HSync = 1'b1;
    ifc.i_VSync = 1'b0;
    clk1();
    chk_all("pre_frame_hrise", 1, 0, 0, 0, 0, 0, 0);
    ifc.i_HSync = 1'b0;
    repeat (2) clk1();
    chk_all("pre_frame_idle", 0, 0, 0, 0, 0, 0, 0);

    // Nominal raster from position 0,0.
    errcnt = 0;
    kk = 0;
    foreach (vecs[i]) begin
      while (kk <= vecs[i].idx) gen_step();
      chk_all($sformatf("vec%0d", vecs[i].idx), vecs[i].hs, vecs[i].vs, vecs[i].col,
              vecs[i].row, vecs[i].fs, vecs[i].lk, vecs[i].er);
    end
    chk("nominal.err_pulses", errcnt, 0);

    // Short line: source restarts its line after col 7 of row 2.
    while (!(gr == 2 && gc == 8)) gen_step();
    chk("pre_short.lock", int'(ifc.o_Locked), 1);
    gc = 0;
    gr = 3;
    errcnt = 0;
    gen_step();
    chk_all("short", 1, 1, 0, 3, 0, 0, 1);
    gen_step();
    chk("short_next.err", int'(ifc.o_Err), 0);
    chk("short_next.col", int'(ifc.o_Col_Count), 1);
    chk("short_next.row", int'(ifc.o_Row_Count), 3);
    wait_fs("relock1");
    chk_all("relock1", 1, 1, 0, 0, 1, 0, 0);
    wait_fs("relock2");
    chk("relock2.lock", int'(ifc.o_Locked), 1);
    chk("short.err_pulses", errcnt, 1);

    // Missing VSync: frame start suppressed, VSync finally rises two lines late.
    while (!(gc == 0 && gr == 0)) gen_step();
    vmask = 1'b1;
    errcnt = 0;
    gen_step();
    chk_all("novsync", 1, 0, 0, 0, 0, 0, 1);
    while (!(gr == 2 && gc == 0)) gen_step();
    vmask = 1'b0;
    gen_step();
    chk_all("late_vsync", 1, 1, 0, 0, 1, 0, 1);
    chk("novsync.err_pulses", errcnt, 2);
    wait_fs("resync");
    chk("resync.err", int'(ifc.o_Err), 1);
    chk("resync.lock", int'(ifc.o_Locked), 0);

    // Aligned frame start: HSync and VSync rise together.
    wait_fs("simul");
    chk_all("simul", 1, 1, 0, 0, 1, 0, 0);
    gen_step();
    chk("simul_once.fs", int'(ifc.o_Frame_Start), 0);
    chk("simul_once.col", int'(ifc.o_Col_Count), 1);
    wait_fs("lock_again");
    chk("lock_again.lock", int'(ifc.o_Locked), 1);

    // Reset mid-line while locked, during vertical blanking.
    while (!(gr == 4 && gc == 2)) gen_step();
    chk("pre_reset.lock", int'(ifc.o_Locked), 1);
    #3;
    rst = 1'b1;
    #1;
    chk_all("async_reset", 0, 0, 0, 0, 0, 0, 0);
    repeat (3) gen_step();
    chk("in_reset.col", int'(ifc.o_Col_Count), 0);
    rst = 1'b0;
    errcnt = 0;
    wait_fs("rst_fs1");
    chk_all("rst_fs1", 1, 1, 0, 0, 1, 0, 0);
    wait_fs("rst_fs2");
    chk("rst_fs2.lock", int'(ifc.o_Locked), 0);
    wait_fs("rst_fs3");
    chk("rst_fs3.lock", int'(ifc.o_Locked), 1);
    chk("after_reset.err_pulses", errcnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
